// File: rtl/mul_pkg.sv
// Shared definitions for the multiply controller: FSM state encoding,
// data width and the default iteration limit.
package mul_pkg;

    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] MAX_ITER_DEFAULT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_ACCUM  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/mul_ctrl_if.sv
// Control/handshake bundle between the multiply controller (slave modport)
// and its environment: request, operand handshake, datapath strobes, status.
interface mul_ctrl_if;

    logic start;
    logic in_valid;
    logic in_ready;
    logic eqz;
    logic LdA;
    logic LdB;
    logic LdP;
    logic clrP;
    logic decB;
    logic busy;
    logic done;
    logic error;

    modport master (
        output start, in_valid, eqz,
        input  in_ready, LdA, LdB, LdP, clrP, decB, busy, done, error
    );

    modport slave (
        input  start, in_valid, eqz,
        output in_ready, LdA, LdB, LdP, clrP, decB, busy, done, error
    );

endinterface

// File: rtl/mul_watchdog.sv
// Accumulate-iteration counter; flags when the count reaches MAX_ITER so the
// controller can abort a runaway multiply.
module mul_watchdog
    import mul_pkg::*;
#(
    parameter logic [DATA_W-1:0] MAX_ITER = MAX_ITER_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [DATA_W-1:0] count_r;

    // Iteration count: cleared on ACCUM entry, bumped on every accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {DATA_W{1'b0}};
        end else if (clr) begin
            count_r <= {DATA_W{1'b0}};
        end else if (inc) begin
            count_r <= count_r + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == MAX_ITER);

endmodule

// File: rtl/mul_ctrl.sv
// Shift-free add/decrement multiply controller sequencing an external datapath.
// Optional iteration timeout enabled by defining MUL_CTRL_TIMEOUT_EN.
module mul_ctrl
    import mul_pkg::*;
#(
    parameter logic [DATA_W-1:0] MAX_ITER = MAX_ITER_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    mul_ctrl_if.slave  bus
);

    state_t state_r;
    state_t state_s;
    logic   in_ready_s, lda_s, ldb_s, ldp_s, clrp_s, decb_s, busy_s, done_s;
    logic   accept_s;
    logic   abort_s;
    logic   timeout_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and strobe decode; reset masks every output immediately.
    always_comb begin
        state_s    = state_r;
        in_ready_s = 1'b0;
        lda_s      = 1'b0;
        ldb_s      = 1'b0;
        ldp_s      = 1'b0;
        clrp_s     = 1'b0;
        decb_s     = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        accept_s   = 1'b0;
        abort_s    = 1'b0;
        if (rst) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        accept_s = 1'b1;
                        state_s  = ST_LOAD_A;
                    end else begin
                        state_s  = ST_IDLE;
                    end
                end
                ST_LOAD_A: begin
                    busy_s     = 1'b1;
                    in_ready_s = 1'b1;
                    lda_s      = bus.in_valid;
                    if (bus.in_valid) begin
                        state_s = ST_LOAD_B;
                    end else begin
                        state_s = ST_LOAD_A;
                    end
                end
                ST_LOAD_B: begin
                    busy_s     = 1'b1;
                    in_ready_s = 1'b1;
                    ldb_s      = bus.in_valid;
                    clrp_s     = bus.in_valid;
                    if (bus.in_valid) begin
                        state_s = ST_ACCUM;
                    end else begin
                        state_s = ST_LOAD_B;
                    end
                end
                ST_ACCUM: begin
                    busy_s = 1'b1;
                    // Natural completion wins over the timeout when both coincide.
                    if (bus.eqz) begin
                        state_s = ST_DONE;
                    end else if (timeout_s) begin
                        abort_s = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        ldp_s   = 1'b1;
                        decb_s  = 1'b1;
                        state_s = ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    busy_s  = 1'b1;
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.LdA      = lda_s;
    assign bus.LdB      = ldb_s;
    assign bus.LdP      = ldp_s;
    assign bus.clrP     = clrp_s;
    assign bus.decB     = decb_s;
    assign bus.busy     = busy_s;
    assign bus.done     = done_s;

`ifdef MUL_CTRL_TIMEOUT_EN
    logic error_r;
    logic acc_entry_s;

    assign acc_entry_s = (state_r == ST_LOAD_B) && bus.in_valid;

    mul_watchdog #(
        .MAX_ITER (MAX_ITER)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (acc_entry_s),
        .inc     (ldp_s),
        .expired (timeout_s)
    );

    // Sticky abort flag, cleared only by the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            error_r <= 1'b0;
        end else if (accept_s) begin
            error_r <= 1'b0;
        end else if (abort_s) begin
            error_r <= 1'b1;
        end else begin
            error_r <= error_r;
        end
    end

    assign bus.error = error_r;
`else
    logic unused_s;

    assign timeout_s = 1'b0;
    assign bus.error = 1'b0;
    assign unused_s  = ^{MAX_ITER, accept_s, abort_s};
`endif

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl with a behavioural A/B/P datapath model.
module tb_mul_ctrl;
    import mul_pkg::*;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        int          lat;
        logic        err;
        int          ldp;
        logic        sid;
    } vec_t;

    typedef struct {
        logic [15:0] p;
        int          lat;
        logic        err;
        int          ldp;
    } exp_t;

`ifdef MUL_CTRL_TIMEOUT_EN
    localparam logic [15:0] TB_MAX = 16'd4;
`else
    localparam logic [15:0] TB_MAX = MAX_ITER_DEFAULT;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = 16'd0;
    logic [15:0] a_r = 16'd0;
    logic [15:0] b_r = 16'd0;
    logic [15:0] p_r = 16'd0;
    int          ldp_cnt = 0;
    int          done_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    vec_t        vecs[6];

    mul_ctrl_if bus ();

    mul_ctrl #(.MAX_ITER(TB_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.eqz = (b_r == 16'd0);

    // Datapath model driven by the controller strobes.
    always @(posedge clk) begin
        if (bus.LdA) a_r <= data_in;
        if (bus.LdB) b_r <= data_in;
        else if (bus.decB) b_r <= b_r - 16'd1;
        if (bus.clrP) p_r <= 16'd0;
        else if (bus.LdP) p_r <= p_r + a_r;
        if (bus.LdP) ldp_cnt <= ldp_cnt + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [8:0] outs();
        return {bus.in_ready, bus.LdA, bus.LdB, bus.LdP, bus.clrP,
                bus.decB, bus.busy, bus.done, bus.error};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sid,
                          input int budget, output int lat, output logic [15:0] p,
                          output logic err, output int ldp, output logic gap,
                          output logic err0);
        int   ldp0;
        logic seen;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        data_in      = a;
        ldp0         = ldp_cnt;
        gap          = 1'b0;
        seen         = 1'b0;
        err0         = 1'b0;
        lat          = -1;
        while (!seen && lat < budget) begin
            @(negedge clk);
            lat++;
            if (lat == 0) begin
                bus.start = 1'b0;
                err0      = bus.error;
            end
            if (lat == 1) data_in = b;
            if (!bus.busy) gap = 1'b1;
            if (bus.done) seen = 1'b1;
        end
        p   = p_r;
        err = bus.error;
        ldp = ldp_cnt - ldp0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_wait: no done within %0d cycles (a=%0d b=%0d)", budget, a, b);
        end
        if (sid) bus.start = 1'b1;
        @(negedge clk);
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_done", bus.done, 1'b0);
        bus.start = 1'b0;
    endtask

    initial begin
        int          lat, ldp, d0, l0;
        logic [15:0] p;
        logic        e, g, e0, prev_err;
        exp_t        ex;

`ifdef MUL_CTRL_TIMEOUT_EN
        vecs[0] = '{16'd7,     16'd5,   16'd28,     7, 1'b1, 4, 1'b0};
        vecs[1] = '{16'd9,     16'd0,   16'd0,      3, 1'b0, 0, 1'b1};
        vecs[2] = '{16'd3,     16'd10,  16'd12,     7, 1'b1, 4, 1'b0};
        vecs[3] = '{16'hFFFF,  16'd2,   16'hFFFE,   5, 1'b0, 2, 1'b0};
        vecs[4] = '{16'h4000,  16'd4,   16'h0000,   7, 1'b0, 4, 1'b0};
        vecs[5] = '{16'd300,   16'd300, 16'd1200,   7, 1'b1, 4, 1'b0};
`else
        vecs[0] = '{16'd7,     16'd5,   16'd35,     8,   1'b0, 5,   1'b0};
        vecs[1] = '{16'd9,     16'd0,   16'd0,      3,   1'b0, 0,   1'b1};
        vecs[2] = '{16'd3,     16'd10,  16'd30,     13,  1'b0, 10,  1'b0};
        vecs[3] = '{16'hFFFF,  16'd2,   16'hFFFE,   5,   1'b0, 2,   1'b0};
        vecs[4] = '{16'h4000,  16'd4,   16'h0000,   7,   1'b0, 4,   1'b0};
        vecs[5] = '{16'd300,   16'd300, 16'd24464,  303, 1'b0, 300, 1'b0};
`endif

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;

        // Reset state, including start asserted while in reset.
        @(negedge clk);
        bus.start = 1'b1;
        chk("rst_outs", outs(), 9'd0);
        @(negedge clk);
        chk("rst_outs_hold", outs(), 9'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outs", outs(), 9'd0);

        // Table-driven operations with a scoreboard.
        prev_err = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("err_hold", bus.error, prev_err);
            exp_q.push_back('{vecs[i].p, vecs[i].lat, vecs[i].err, vecs[i].ldp});
            run_op(vecs[i].a, vecs[i].b, vecs[i].sid, 400, lat, p, e, ldp, g, e0);
            ex = exp_q.pop_front();
            chk("product", p, ex.p);
            chk("latency", lat, ex.lat);
            chk("error", e, ex.err);
            chk("ldp_pulses", ldp, ex.ldp);
            chk("err_clear_on_start", e0, 1'b0);
            chk("busy_gap", g, 1'b0);
            prev_err = ex.err;
        end

        // Stall in LOAD_A, then start pulsed during ACCUM.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.in_valid = 1'b0;
        data_in      = 16'd6;
        d0           = done_cnt;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("stall_lda", bus.LdA, 1'b0);
            chk("stall_ready", bus.in_ready, 1'b1);
            if (k < 3) @(negedge clk);
        end
        bus.in_valid = 1'b1;
        #1;
        chk("stall_release_lda", bus.LdA, 1'b1);
        @(negedge clk);
        data_in = 16'd3;
        @(negedge clk);
        chk("accum_ready", bus.in_ready, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("ignore_done_cnt", done_cnt - d0, 1);
        chk("ignore_product", p_r, 16'd18);
        chk("ignore_idle", bus.busy, 1'b0);

        // Reset asserted in the third ACCUM cycle.
        @(negedge clk);
        bus.start = 1'b1;
        data_in   = 16'd4;
        d0        = done_cnt;
        l0        = ldp_cnt;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        data_in = 16'd10;
        repeat (3) @(negedge clk);
        chk("mid_accum_ldp", bus.LdP, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", outs(), 9'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after_rst_outs", outs(), 9'd0);
        repeat (20) @(negedge clk);
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_ldp_total", ldp_cnt - l0, 2);
        chk("rst_idle_outs", outs(), 9'd0);

`ifdef MUL_CTRL_TIMEOUT_EN
        // Timeout abort, error held in IDLE, cleared by the next start.
        run_op(16'd3, 16'd10, 1'b0, 100, lat, p, e, ldp, g, e0);
        chk("to_ldp", ldp, 4);
        chk("to_product", p, 16'd12);
        chk("to_b_left", b_r, 16'd6);
        chk("to_error", e, 1'b1);
        chk("to_latency", lat, 7);
        repeat (3) @(negedge clk);
        chk("to_error_held", bus.error, 1'b1);
        run_op(16'd1, 16'd1, 1'b0, 100, lat, p, e, ldp, g, e0);
        chk("to_error_cleared", e0, 1'b0);
        chk("to_next_product", p, 16'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
